regbank_arbiter: RTL
====================

// Module: regbank_arbiter
// PURPOSE
//  Single-port arbiter/sequencer for the 16x3 colour register bank. Shares the bank's one
//  address/write port between three requesters: VGA pixel reads (highest priority), keypad
//  read-modify-write colour-cycle updates (middle) and a periodic display scanner (lowest).
//  Sits between Teclado, test_VGA, Display and BancoRegistro in Top; it is the only bank driver.
// PARAMETERS
//  AW           4      bank address width (2**AW entries)
//  DW           3      colour/data width
//  DISP_PERIOD  50000  clk cycles between display-scanner read attempts (>=2)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   asynchronous, active-low reset
//  vga_req      in   1   VGA wants entry vga_addr this cycle
//  vga_addr     in   AW  VGA read address
//  vga_data     out  DW  registered read data for VGA
//  vga_valid    out  1   vga_data updated (1-cycle pulse)
//  key_opr      in   1   keypad pulse: cycle colour of entry key_pos
//  key_pos      in   AW  keypad target address
//  key_busy     out  1   keypad request pending/in progress
//  key_drop     out  1   1-cycle pulse: key_opr ignored (request already pending)
//  disp_pos     out  AW  entry last shown on 7-seg display
//  disp_data    out  DW  colour of disp_pos
//  bank_addr    out  AW  bank address
//  bank_we      out  1   bank write enable
//  bank_wdata   out  DW  bank write data
//  bank_rdata   in   DW  bank read data, combinational from bank_addr
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, FSM=IDLE, key pending cleared, scanner index 0,
//   period counter 0. Released synchronously on first clk edge with rst=1.
//  Grant per cycle: vga_req > key FSM step > display read. Exactly one owner per cycle.
//  VGA: cycle with vga_req=1 -> bank_addr=vga_addr, bank_we=0; next edge vga_data<=bank_rdata,
//   vga_valid=1 for one cycle (latency 1). VGA is never stalled. Back-to-back reqs each served.
//  Key FSM states: IDLE, KEY_RD, KEY_WR, DISP_RD.
//   - key_opr=1 with no pending key: latch key_pos, key_busy<=1. key_opr while key_busy=1:
//     dropped, key_drop pulse next cycle, latched address unchanged.
//   - IDLE -> KEY_RD when key pending; -> DISP_RD when period counter expired; key wins tie.
//   - KEY_RD (not pre-empted): bank_addr=latched pos; capture bank_rdata into tmp; -> KEY_WR.
//   - KEY_WR (not pre-empted): bank_addr=latched pos, bank_we=1, bank_wdata=(tmp+1) mod 2**DW
//     (7 -> 0 wraps); -> IDLE, key_busy<=0 on same edge.
//   - DISP_RD (not pre-empted): bank_addr=scan index; disp_pos<=index, disp_data<=bank_rdata;
//     index<=index+1 wraps 2**AW-1 -> 0; period counter restarts; -> IDLE.
//   - Any cycle with vga_req=1: FSM holds state, no captures, no write, no counter restart.
//  Period counter: counts in IDLE/DISP_RD up to DISP_PERIOD-1 and saturates until DISP_RD served.
//  Key and VGA same address same cycle: VGA sees pre-write value; write occurs later in KEY_WR.
//  key_opr on the same edge KEY_WR completes: accepted as a new request (busy stays 1).
//  Reset mid-operation: pending key and partial RMW discarded; no write issued after reset.
//  bank_we is 1 only in unpreempted KEY_WR; never asserted in reset or any other state.
// TESTING
//  1 Reset: hold rst=0 5 cycles with random inputs -> all outputs 0, bank_we never 1.
//  2 Key RMW: bank[5]=3, key_opr pulse key_pos=5, vga_req=0 -> write 4 to addr 5 at 3rd edge,
//    key_busy low after; with bank[5]=7 -> writes 0 (wrap).
//  3 VGA priority: vga_req=1 continuously 20 cycles while key pending for addr 2 -> no bank_we,
//    vga_valid every cycle; drop vga_req -> write to addr 2 within 2 cycles.
//  4 Drop: two key_opr pulses 1 cycle apart (pos 1 then 9) -> only addr 1 updated, key_drop=1 once.
//  5 Scanner: DISP_PERIOD=4, bank[i]=i mod 8, no other reqs -> disp_pos 0,1,..,15,0 every
//    4 cycles, disp_data=disp_pos mod 8; key request issued at expiry wins, scan delayed.
//  6 Reset in KEY_RD (rst=0 one cycle) -> bank contents unchanged, key_busy=0, FSM IDLE.

Source files
------------

// File: rtl/regbank_arbiter.sv
// regbank_arbiter
//   Single-port arbiter/sequencer for the colour register bank. Three requesters
//   share the bank's one address/write port, in fixed priority:
//     1. VGA pixel reads      (never stalled, registered data one cycle later)
//     2. keypad colour cycle  (read-modify-write: value <= value + 1, wrapping)
//     3. display scanner      (one entry every DISP_PERIOD cycles, round robin)
//   This block is the only driver of the bank port.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   vga_req, vga_addr        VGA read request / address
//   vga_data, vga_valid      registered read data / one-cycle update pulse
//   key_opr, key_pos         keypad pulse / target entry
//   key_busy, key_drop       keypad request pending / pulse when a key_opr was ignored
//   disp_pos, disp_data      entry last shown on the 7-seg display and its colour
//   bank_addr, bank_we,
//   bank_wdata, bank_rdata   bank port (bank_rdata is combinational from bank_addr)
module regbank_arbiter #(
  parameter int AW          = 4,
  parameter int DW          = 3,
  parameter int DISP_PERIOD = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic [DW-1:0] vga_data,
  output logic          vga_valid,
  input  logic          key_opr,
  input  logic [AW-1:0] key_pos,
  output logic          key_busy,
  output logic          key_drop,
  output logic [AW-1:0] disp_pos,
  output logic [DW-1:0] disp_data,
  output logic [AW-1:0] bank_addr,
  output logic          bank_we,
  output logic [DW-1:0] bank_wdata,
  input  logic [DW-1:0] bank_rdata
);

  localparam int            CW          = $clog2(DISP_PERIOD);
  localparam logic [CW-1:0] CNT_MAX     = CW'(DISP_PERIOD - 1);
  // The served DISP_RD cycle is itself the first cycle of the next period,
  // so scans land exactly DISP_PERIOD cycles apart.
  localparam logic [CW-1:0] CNT_RESTART = CW'(1);

  typedef enum logic [1:0] {IDLE, KEY_RD, KEY_WR, DISP_RD} state_t;

  state_t        state, state_nxt;
  logic          active;
  logic [AW-1:0] key_addr;
  logic [DW-1:0] key_rdata;
  logic [AW-1:0] scan_idx;
  logic [CW-1:0] cnt;

  logic vga_go, fsm_go, expired;
  logic rd_done, wr_done, disp_done, key_accept;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  function automatic logic [DW-1:0] wrap_inc(input logic [DW-1:0] v);
    return v + DW'(1);
  endfunction

  // 'active' holds everything quiet until the first clock edge after reset
  // is released, so outputs stay 0 even if rst rises mid-cycle.
  assign vga_go    = active & vga_req;
  assign fsm_go    = active & ~vga_req;
  assign expired   = (cnt == CNT_MAX);
  assign rd_done   = fsm_go && (state == KEY_RD);
  assign wr_done   = fsm_go && (state == KEY_WR);
  assign disp_done = fsm_go && (state == DISP_RD);
  // A key pulse landing on the edge that finishes the write starts a new request.
  assign key_accept = active && key_opr && (!key_busy || wr_done);

  always_comb begin
    state_nxt  = state;
    bank_addr  = '0;
    bank_we    = 1'b0;
    bank_wdata = '0;
    if (vga_go) begin
      bank_addr = vga_addr;
    end else if (fsm_go) begin
      unique case (state)
        IDLE: begin
          // Key work (already pending or arriving now) wins over the scanner.
          if (key_busy || key_accept) state_nxt = KEY_RD;
          else if (expired)           state_nxt = DISP_RD;
        end
        KEY_RD: begin
          bank_addr = key_addr;
          state_nxt = KEY_WR;
        end
        KEY_WR: begin
          bank_addr  = key_addr;
          bank_we    = 1'b1;
          bank_wdata = wrap_inc(key_rdata);
          state_nxt  = IDLE;
        end
        DISP_RD: begin
          bank_addr = scan_idx;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      active    <= 1'b0;
      vga_data  <= '0;
      vga_valid <= 1'b0;
      key_busy  <= 1'b0;
      key_drop  <= 1'b0;
      key_addr  <= '0;
      disp_pos  <= '0;
      disp_data <= '0;
      scan_idx  <= '0;
      cnt       <= '0;
    end else begin
      active    <= 1'b1;
      state     <= state_nxt;
      vga_valid <= vga_go;
      key_drop  <= active && key_opr && !key_accept;
      if (vga_go) vga_data <= bank_rdata;
      if (key_accept) begin
        key_busy <= 1'b1;
        key_addr <= key_pos;
      end else if (wr_done) begin
        key_busy <= 1'b0;
      end
      if (disp_done) begin
        disp_pos  <= scan_idx;
        disp_data <= bank_rdata;
        scan_idx  <= scan_idx + AW'(1);
        cnt       <= CNT_RESTART;
      end else if (active && (state == IDLE || state == DISP_RD)) begin
        cnt <= sat_inc(cnt);
      end
    end
  end

  // Read half of the keypad read-modify-write; only meaningful while in KEY_WR.
  always_ff @(posedge clk) begin
    if (rd_done) key_rdata <= bank_rdata;
  end

endmodule
